// File: rtl/qracc_sram_ctrl.sv
// qracc_sram_ctrl: single-port SRAM macro controller.
// Sequences precharge, write pulse and sense phases for one row access at a
// time. Macro-side strobes are registered and decoded from the next state so
// they change only on clock edges. Requests are blocked while MAC mode is on.
module qracc_sram_ctrl #(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = 1,
  parameter int wrCycles  = 1,
  parameter int saCycles  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_valid_i,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  input  logic                       mac_en_i,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int AW = $clog2(numRows);
  localparam int MAX_A = (pchCycles > wrCycles) ? pchCycles : wrCycles;
  localparam int MAX_CYC = (MAX_A > saCycles) ? MAX_A : saCycles;
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [numRows-1:0] WL_ONE = {{(numRows-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    WRPULSE   = 2'd2,
    SENSE     = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [CW-1:0]       cnt_r;
  logic [AW-1:0]       addr_r;
  logic [numCols-1:0]  data_r;
  logic                wr_r;
  logic                rq_ready_s;
  logic                accept_s;
  logic [AW-1:0]       addr_nx_s;
  logic [numCols-1:0]  data_nx_s;
  logic                rd_valid_r;
  logic [numCols-1:0]  rd_data_r;

  logic [numRows-1:0]  wl_s;
  logic                pch_s;
  logic                write_s;
  logic [numCols-1:0]  wr_data_s;
  logic [numCols-1:0]  csel_s;
  logic                saen_s;
  logic [numRows-1:0]  wl_r;
  logic                pch_r;
  logic                write_r;
  logic [numCols-1:0]  wr_data_r;
  logic [numCols-1:0]  csel_r;
  logic                saen_r;

  // Phase duration reload value for the state being entered.
  function automatic logic [CW-1:0] reload_val(input state_t st);
    logic [CW-1:0] v;
    case (st)
      PRECHARGE: v = CW'(pchCycles - 1);
      WRPULSE:   v = CW'(wrCycles - 1);
      SENSE:     v = CW'(saCycles - 1);
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Ready depends only on the registered state and the MAC-mode input.
  always_comb begin
    rq_ready_s = (state_r == IDLE) && !mac_en_i;
    accept_s   = rq_valid_i && rq_ready_s;
    if (accept_s) begin
      addr_nx_s = addr_i;
      data_nx_s = wr_data_i;
    end else begin
      addr_nx_s = addr_r;
      data_nx_s = data_r;
    end
  end

  assign rq_ready_o = rq_ready_s;
  assign rd_valid_o = rd_valid_r;
  assign rd_data_o  = rd_data_r;
  assign WL         = wl_r;
  assign PCH        = pch_r;
  assign WRITE      = write_r;
  assign WR_DATA    = wr_data_r;
  assign CSEL       = csel_r;
  assign SAEN       = saen_r;

  // State register, phase counter and request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= '0;
      data_r  <= '0;
      wr_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (state_nx_s != state_r) begin
        cnt_r <= reload_val(state_nx_s);
      end else if (cnt_r != '0) begin
        cnt_r <= cnt_r - CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      addr_r <= addr_nx_s;
      data_r <= data_nx_s;
      if (accept_s) begin
        wr_r <= rq_wr_i;
      end else begin
        wr_r <= wr_r;
      end
    end
  end

  // Next-state logic: each phase lasts until its counter has run down to zero.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = PRECHARGE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PRECHARGE: begin
        if (cnt_r == '0) begin
          if (wr_r) begin
            state_nx_s = WRPULSE;
          end else begin
            state_nx_s = SENSE;
          end
        end else begin
          state_nx_s = PRECHARGE;
        end
      end
      WRPULSE: begin
        if (cnt_r == '0) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WRPULSE;
        end
      end
      SENSE: begin
        if (cnt_r == '0) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = SENSE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Macro strobe decode for the upcoming state; PCH and WL are mutually exclusive.
  always_comb begin
    wl_s      = '0;
    pch_s     = 1'b0;
    write_s   = 1'b0;
    wr_data_s = '0;
    csel_s    = '0;
    saen_s    = 1'b0;
    case (state_nx_s)
      PRECHARGE: begin
        pch_s = 1'b1;
      end
      WRPULSE: begin
        wl_s      = WL_ONE << addr_nx_s;
        write_s   = 1'b1;
        wr_data_s = data_nx_s;
        csel_s    = '1;
      end
      SENSE: begin
        wl_s   = WL_ONE << addr_nx_s;
        saen_s = 1'b1;
        csel_s = '1;
      end
      default: begin
        wl_s = '0;
      end
    endcase
  end

  // Registered macro strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wl_r      <= '0;
      pch_r     <= 1'b0;
      write_r   <= 1'b0;
      wr_data_r <= '0;
      csel_r    <= '0;
      saen_r    <= 1'b0;
    end else begin
      wl_r      <= wl_s;
      pch_r     <= pch_s;
      write_r   <= write_s;
      wr_data_r <= wr_data_s;
      csel_r    <= csel_s;
      saen_r    <= saen_s;
    end
  end

  // Read result: captured on the final sense edge, invalidated by a new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else if (accept_s) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= rd_data_r;
    end else if ((state_r == SENSE) && (cnt_r == '0)) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= SA_OUT;
    end else begin
      rd_valid_r <= rd_valid_r;
      rd_data_r  <= rd_data_r;
    end
  end

endmodule
